pcn_stoch: RTL and testbench

- Stochastic parity check node (PCN) of degree DC. Returns the extrinsic parity bits R to the equality nodes (EN) that drive its Q inputs; it is the check-node side of the EN<->PCN stochastic bit exchange.
- Tracks check satisfaction and runs a per-decode session FSM.
- Asserts SAT after SAT_TH consecutive satisfied cycles, or TIMEOUT after MAX_CYC cycles, so the decoder top can terminate early.

---
 rtl/pcn_pkg.sv | 22 ++
 rtl/pcn_parity.sv | 18 +
 rtl/pcn_stoch.sv | 161 ++++++++++++++++
 tb/tb_pcn_stoch.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pcn_pkg.sv
// Shared types and defaults for the stochastic parity check node.
package pcn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        FIN_SAT = 2'd2,
        FIN_TO  = 2'd3
    } pcn_state_e;

    localparam int PCN_DC_DEF      = 6;
    localparam int PCN_SAT_TH_DEF  = 16;
    localparam int PCN_MAX_CYC_DEF = 1024;
    localparam int PCN_CNT_W_DEF   = 11;
    localparam int PCN_SATC_W_DEF  = 5;

    // True when a counter of width w can hold the value lim.
    function automatic bit width_ok(input int w, input int lim);
        return (longint'(1) << w) > longint'(lim);
    endfunction

endpackage

// File: rtl/pcn_parity.sv
// Combinational parity core: P is the XOR of all inputs, E[i] excludes input i.
module pcn_parity #(
    parameter int DC = 6
) (
    input  logic [DC-1:0] q,
    output logic          p,
    output logic [DC-1:0] e
);

    assign p = ^q;

    generate
        for (genvar gi = 0; gi < DC; gi++) begin : g_ext
            assign e[gi] = p ^ q[gi];
        end
    endgenerate

endmodule

// File: rtl/pcn_stoch.sv
// Stochastic parity check node with per-decode session FSM, SAT/TIMEOUT detection.
// Build option: define PCN_PIPE_EN to register Q before the parity core.
module pcn_stoch
    import pcn_pkg::*;
#(
    parameter int DC      = PCN_DC_DEF,
    parameter int SAT_TH  = PCN_SAT_TH_DEF,
    parameter int MAX_CYC = PCN_MAX_CYC_DEF,
    parameter int CNT_W   = PCN_CNT_W_DEF,
    parameter int SATC_W  = PCN_SATC_W_DEF
) (
    input  logic             CLK,
    input  logic             INIT,
    input  logic             START,
    input  logic [DC-1:0]    Q,
    output logic [DC-1:0]    R,
    output logic             BUSY,
    output logic             SAT,
    output logic             TIMEOUT,
    output logic             DONE,
    output logic [CNT_W-1:0] CYC
);

    pcn_state_e        state_q, state_d;
    logic [DC-1:0]     r_q, r_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [SATC_W-1:0] satcnt_q, satcnt_d;
    logic              busy_q, busy_d;
    logic              sat_q, sat_d;
    logic              to_q, to_d;
    logic              done_q, done_d;

    logic [DC-1:0]     par_in;
    logic              par_p;
    logic [DC-1:0]     par_e;
    logic              eval;
    logic              start_session;

    assign start_session = START && (state_q != RUN);

`ifdef PCN_PIPE_EN
    logic [DC-1:0] qreg_q, qreg_d;
    logic          valid_q, valid_d;

    // The first RUN edge only primes qreg; evaluation starts on the next one.
    always_comb begin
        qreg_d  = qreg_q;
        valid_d = valid_q;
        if (state_q == RUN) begin
            qreg_d  = Q;
            valid_d = 1'b1;
        end else if (start_session) begin
            qreg_d  = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            qreg_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            qreg_q  <= qreg_d;
            valid_q <= valid_d;
        end
    end

    assign par_in = qreg_q;
    assign eval   = valid_q;
`else
    assign par_in = Q;
    assign eval   = 1'b1;
`endif

    pcn_parity #(.DC(DC)) u_parity (
        .q (par_in),
        .p (par_p),
        .e (par_e)
    );

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        cyc_d    = cyc_q;
        satcnt_d = satcnt_q;
        busy_d   = busy_q;
        sat_d    = sat_q;
        to_d     = to_q;
        done_d   = done_q;

        case (state_q)
            RUN: begin
                if (eval) begin
                    r_d      = par_e;
                    cyc_d    = cyc_q + CNT_W'(1);
                    satcnt_d = par_p ? '0 : satcnt_q + SATC_W'(1);
                    // Satisfaction is checked first so it wins over a simultaneous budget hit.
                    if (!par_p && satcnt_q == SATC_W'(SAT_TH - 1)) begin
                        state_d = FIN_SAT;
                        busy_d  = 1'b0;
                        sat_d   = 1'b1;
                        done_d  = 1'b1;
                    end else if (cyc_q == CNT_W'(MAX_CYC - 1)) begin
                        state_d = FIN_TO;
                        busy_d  = 1'b0;
                        to_d    = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (state_q == IDLE) begin
                    r_d = '0;
                end
                if (start_session) begin
                    state_d  = RUN;
                    cyc_d    = '0;
                    satcnt_d = '0;
                    busy_d   = 1'b1;
                    sat_d    = 1'b0;
                    to_d     = 1'b0;
                    done_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_q  <= IDLE;
            r_q      <= '0;
            cyc_q    <= '0;
            satcnt_q <= '0;
            busy_q   <= 1'b0;
            sat_q    <= 1'b0;
            to_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            cyc_q    <= cyc_d;
            satcnt_q <= satcnt_d;
            busy_q   <= busy_d;
            sat_q    <= sat_d;
            to_q     <= to_d;
            done_q   <= done_d;
        end
    end

    assign R       = r_q;
    assign BUSY    = busy_q;
    assign SAT     = sat_q;
    assign TIMEOUT = to_q;
    assign DONE    = done_q;
    assign CYC     = cyc_q;

    a_cnt_w:  assert property (@(posedge CLK) width_ok(CNT_W, MAX_CYC));
    a_satc_w: assert property (@(posedge CLK) width_ok(SATC_W, SAT_TH));
    a_dc_min: assert property (@(posedge CLK) DC >= 2);

endmodule

// File: tb/tb_pcn_stoch.sv
// Scoreboard bench for pcn_stoch: a session-level reference model predicts outputs after each edge.
module tb_pcn_stoch;

    localparam int DC      = 6;
    localparam int SAT_TH  = 4;
    localparam int MAX_CYC = 8;
    localparam int CNT_W   = 4;
    localparam int SATC_W  = 3;

    logic             clk = 1'b0;
    logic             init = 1'b1;
    logic             start = 1'b0;
    logic [DC-1:0]    q = '0;
    logic [DC-1:0]    r;
    logic             busy, sat, tmo, done;
    logic [CNT_W-1:0] cyc;

    typedef struct packed {
        logic [DC-1:0]    r;
        logic             busy;
        logic             sat;
        logic             tmo;
        logic             done;
        logic [CNT_W-1:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    // Reference model: session mode plus the history of parities seen in this session.
    bit            m_run = 0;
    logic [DC-1:0] m_r = '0;
    int            m_cyc = 0;
    bit            m_sat = 0;
    bit            m_tmo = 0;
    bit            m_hist[$];
    bit            m_first = 0;
    logic [DC-1:0] m_qprev = '0;

    pcn_stoch #(
        .DC(DC), .SAT_TH(SAT_TH), .MAX_CYC(MAX_CYC), .CNT_W(CNT_W), .SATC_W(SATC_W)
    ) dut (
        .CLK(clk), .INIT(init), .START(start), .Q(q), .R(r),
        .BUSY(busy), .SAT(sat), .TIMEOUT(tmo), .DONE(done), .CYC(cyc)
    );

    always #5 clk = ~clk;

    function automatic bit parity(input logic [DC-1:0] v);
        return bit'($countones(v) % 2);
    endfunction

    function automatic logic [DC-1:0] extrinsic(input logic [DC-1:0] v);
        logic [DC-1:0] res;
        logic [DC-1:0] m;
        for (int i = 0; i < DC; i++) begin
            m      = v;
            m[i]   = 1'b0;
            res[i] = parity(m);
        end
        return res;
    endfunction

    function automatic int trailing_zeros();
        int n = 0;
        for (int i = m_hist.size() - 1; i >= 0; i--) begin
            if (m_hist[i]) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [DC-1:0] q_with_parity(input bit p);
        logic [DC-1:0] v;
        v = DC'($urandom);
        if (parity(v) != p) v[0] = ~v[0];
        return v;
    endfunction

    task automatic model_step(input bit i_init, input bit i_start, input logic [DC-1:0] i_q);
        logic [DC-1:0] qe;
        bit            ev;
        if (i_init) begin
            m_run = 0; m_r = '0; m_cyc = 0; m_sat = 0; m_tmo = 0;
            m_hist.delete(); m_first = 0; m_qprev = '0;
        end else if (m_run) begin
`ifdef PCN_PIPE_EN
            ev      = !m_first;
            qe      = m_qprev;
            m_first = 0;
            m_qprev = i_q;
`else
            ev = 1;
            qe = i_q;
`endif
            if (ev) begin
                m_hist.push_back(parity(qe));
                m_r   = extrinsic(qe);
                m_cyc = m_cyc + 1;
                if (trailing_zeros() >= SAT_TH) begin
                    m_sat = 1; m_run = 0;
                end else if (m_cyc == MAX_CYC) begin
                    m_tmo = 1; m_run = 0;
                end
            end
        end else if (i_start) begin
            m_run = 1; m_cyc = 0; m_sat = 0; m_tmo = 0;
            m_hist.delete(); m_first = 1; m_qprev = '0;
        end
    endtask

    task automatic step(input bit i_init, input bit i_start, input logic [DC-1:0] i_q);
        exp_t e;
        @(negedge clk);
        init  = i_init;
        start = i_start;
        q     = i_q;
        model_step(i_init, i_start, i_q);
        e.r    = m_r;
        e.busy = m_run;
        e.sat  = m_sat;
        e.tmo  = m_tmo;
        e.done = m_sat | m_tmo;
        e.cyc  = CNT_W'(m_cyc);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL txn %0d %s: got %0d expected %0d", txn, name, act, req);
        end
    endtask

    // Monitor: one expected snapshot per edge, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            chk("R", int'(r), int'(e.r));
            chk("BUSY", int'(busy), int'(e.busy));
            chk("SAT", int'(sat), int'(e.sat));
            chk("TIMEOUT", int'(tmo), int'(e.tmo));
            chk("DONE", int'(done), int'(e.done));
            chk("CYC", int'(cyc), int'(e.cyc));
            $display("txn %0d init=%0b start=%0b q=%b -> R=%b busy=%0b sat=%0b to=%0b done=%0b cyc=%0d",
                     txn, init, start, q, r, busy, sat, tmo, done, cyc);
        end
    end

    initial begin
        // Reset with START asserted: INIT must dominate.
        step(1, 1, 6'b101101);
        step(1, 1, 6'b010011);

        // Session 1: R tracks E, then four satisfied cycles reach SAT; R freezes afterwards.
        step(0, 1, 6'b000000);
        step(0, 0, 6'b000011);
        step(0, 0, 6'b000001);
        for (int k = 0; k < 4; k++) step(0, 0, 6'b000000);
        for (int k = 0; k < 3; k++) step(0, 0, DC'($urandom));

        // Session 2: parity pattern 0,0,0,1,0,0,0,0 -> SAT on the same edge as budget exhaustion.
        step(0, 1, 6'b111111);
        begin
            bit pat[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
            for (int k = 0; k < 8; k++) step(0, 0, q_with_parity(pat[k]));
        end
        step(0, 0, 6'b000001);

        // Session 3: permanently unsatisfied -> TIMEOUT, then restart from FIN_TO.
        step(0, 1, 6'b000001);
        for (int k = 0; k < 9; k++) step(0, 0, 6'b000001);
        step(0, 1, 6'b000000);
        step(0, 0, 6'b000101);
        step(0, 0, 6'b000001);

        // INIT in the middle of a run.
        step(1, 0, 6'b000000);
        step(0, 1, 6'b000000);
        for (int k = 0; k < 3; k++) step(0, 0, q_with_parity(1));
        step(1, 0, 6'b110000);
        step(0, 0, 6'b110000);

        // Randomized traffic biased towards satisfied parity.
        for (int k = 0; k < 400; k++) begin
            bit ri, rs;
            logic [DC-1:0] rq;
            ri = ($urandom_range(0, 59) == 0);
            rs = ($urandom_range(0, 3) == 0);
            rq = ($urandom_range(0, 2) == 0) ? q_with_parity(1) : q_with_parity(0);
            step(ri, rs, rq);
        end

        // Drain: the scoreboard must be empty shortly after the last edge.
        repeat (2) @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
